// File: rtl/wb_bram_burst.sv
// Wishbone B3 block RAM with classic and incrementing/wrapping burst support; WB_BRAM_ERR_EN adds out-of-range error termination.
// Latency: first ack one cycle after request, then one beat per cycle in a burst (classic: one beat per two cycles).
// Backpressure: the slave never stalls a matching burst; mismatched address or dropped strobe ends the burst with one wait state.
module wb_bram_burst #(
    parameter int WORDS    = 2048,
    parameter int AW       = 11,
    parameter int DW       = 32,
    parameter     MEM_FILE = "none"
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic            wb_ack_o,
    output logic            wb_err_o
);

`ifdef WB_BRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int          SW    = DW / 8;
    localparam int          OFF   = $clog2(SW);
    localparam logic [AW:0] LIMIT = (AW+1)'(WORDS);

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

    state_t         state;
    logic [DW-1:0]  mem [0:WORDS-1];
    logic [AW-1:0]  word;
    logic [AW-1:0]  pred;
    logic [AW-1:0]  nxt;
    logic [AW-1:0]  mask;
    logic           req;
    logic           in_rng;
    logic           nxt_rng;
    logic           wr_en;
    logic           unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign word       = wb_adr_i[AW+OFF-1:OFF];
    assign unused_adr = ^wb_adr_i;
    assign in_rng     = {1'b0, word} < LIMIT;
    assign nxt_rng    = {1'b0, nxt} < LIMIT;

    // Wrap bursts only advance the low index bits; linear uses the full mask.
    always_comb begin
        case (wb_bte_i)
            2'b01:   mask = AW'(4'h3);
            2'b10:   mask = AW'(4'h7);
            2'b11:   mask = AW'(4'hF);
            default: mask = '1;
        endcase
        nxt = (word & ~mask) | ((word + AW'(1)) & mask);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            pred     <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && !wb_err_o) begin
                        if (ERR_EN && !in_rng) begin
                            wb_err_o <= 1'b1;
                            wb_dat_o <= '0;
                        end else begin
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= in_rng ? mem[word] : '0;
                            pred     <= word;
                            state    <= (wb_cti_i == 3'b010) ? BURST : CLASSIC;
                        end
                    end
                end
                CLASSIC: state <= IDLE;
                BURST: begin
                    // The next beat is acked speculatively from the predicted address.
                    if (req && word == pred && wb_cti_i == 3'b010) begin
                        if (ERR_EN && !nxt_rng) begin
                            wb_err_o <= 1'b1;
                            wb_dat_o <= '0;
                            state    <= IDLE;
                        end else begin
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= nxt_rng ? mem[nxt] : '0;
                            pred     <= nxt;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_en = rst_i & req & wb_we_i & wb_ack_o & in_rng;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < SW; b++) begin
                if (wb_sel_i[b]) mem[word][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: classic, linear/wrap bursts, address mismatch, mid-burst reset, out-of-range access.
module tb_wb_bram_burst;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, err_a, ack_b, err_b;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] b_adr [8];
    logic [31:0] b_wd  [8];
    logic [31:0] b_rd  [8];

    always #5 clk_i = ~clk_i;

    wb_bram_burst u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(dat_a), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_ack_o(ack_a), .wb_err_o(err_a)
    );

    wb_bram_burst #(.WORDS(1000), .AW(10)) u_oor (
        .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(dat_b), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_ack_o(ack_b), .wb_err_o(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_cti_i = cti;
        wb_bte_i = bte;
    endtask

    task automatic idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_cti_i = 3'b000;
        wb_bte_i = 2'b00;
    endtask

    task automatic classic(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic chk_rd, input logic [31:0] exp);
        drive(we, adr, dat, sel, 3'b000, 2'b00);
        step();
        chk({tag, ".ack"}, 32'(ack_a), 32'd1);
        if (chk_rd) chk({tag, ".dat"}, dat_a, exp);
        step();
        chk({tag, ".gap"}, 32'(ack_a), 32'd0);
        idle();
    endtask

    task automatic run_burst(input string tag, input logic we, input logic [1:0] bte, input int n);
        drive(we, b_adr[0], b_wd[0], 4'hF, (n == 1) ? 3'b111 : 3'b010, bte);
        step();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.ack%0d", tag, i), 32'(ack_a), 32'd1);
            if (!we) chk($sformatf("%s.dat%0d", tag, i), dat_a, b_rd[i]);
            step();
            if (i < n - 1)
                drive(we, b_adr[i+1], b_wd[i+1], 4'hF, (i + 1 == n - 1) ? 3'b111 : 3'b010, bte);
            else
                idle();
        end
        chk({tag, ".end"}, 32'(ack_a), 32'd0);
    endtask

    task automatic oor_access(input string tag, input logic we, input logic [31:0] dat);
        drive(we, 32'h0000_0FA0, dat, 4'hF, 3'b000, 2'b00);
        step();
`ifdef WB_BRAM_ERR_EN
        chk({tag, ".err"}, 32'(err_b), 32'd1);
        chk({tag, ".ack"}, 32'(ack_b), 32'd0);
`else
        chk({tag, ".err"}, 32'(err_b), 32'd0);
        chk({tag, ".ack"}, 32'(ack_b), 32'd1);
`endif
        chk({tag, ".dat"}, dat_b, 32'd0);
        chk({tag, ".excl"}, 32'(ack_b & err_b), 32'd0);
        step();
        chk({tag, ".ack_lo"}, 32'(ack_b), 32'd0);
        chk({tag, ".err_lo"}, 32'(err_b), 32'd0);
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        rst_i    = 1'b1;
        #2 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.ack", 32'(ack_a), 32'd0);
        chk("rst.err", 32'(err_a), 32'd0);
        chk("rst.dat", dat_a, 32'd0);
        chk("rst.ack_b", 32'(ack_b), 32'd0);
        chk("rst.err_b", 32'(err_b), 32'd0);
        @(negedge clk_i) rst_i = 1'b1;
        step();

        classic("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        classic("rd10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF);

        classic("wr20a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
        classic("wr20b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0);
        classic("rd20", 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 32'h11BB_33DD);
        classic("wr20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0);
        classic("rd20z", 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 32'h11BB_33DD);

        // Strobe held across classic reads: ack every other cycle.
        drive(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 2'b00);
        step(); chk("hold.c1", 32'(ack_a), 32'd1); chk("hold.d1", dat_a, 32'hDEAD_BEEF);
        step(); chk("hold.c2", 32'(ack_a), 32'd0);
        step(); chk("hold.c3", 32'(ack_a), 32'd1);
        step(); chk("hold.c4", 32'(ack_a), 32'd0);
        idle();

        for (int i = 0; i < 8; i++) begin
            b_adr[i] = 32'h100 + 32'(4 * i);
            b_wd[i]  = 32'hB000_0040 + 32'(i);
            b_rd[i]  = b_wd[i];
        end
        run_burst("lin_wr", 1'b1, 2'b00, 8);
        run_burst("lin_rd", 1'b0, 2'b00, 8);

        b_adr[0] = 32'h118; b_rd[0] = 32'hB000_0046;
        b_adr[1] = 32'h11C; b_rd[1] = 32'hB000_0047;
        b_adr[2] = 32'h100; b_rd[2] = 32'hB000_0040;
        b_adr[3] = 32'h104; b_rd[3] = 32'hB000_0041;
        run_burst("wrap8_rd", 1'b0, 2'b10, 4);

        b_adr[0] = 32'h0C; b_wd[0] = 32'hC0C0_0003;
        b_adr[1] = 32'h00; b_wd[1] = 32'hC0C0_0000;
        b_adr[2] = 32'h04; b_wd[2] = 32'hC0C0_0001;
        b_adr[3] = 32'h08; b_wd[3] = 32'hC0C0_0002;
        for (int i = 0; i < 4; i++) b_rd[i] = b_wd[i];
        run_burst("wrap4_wr", 1'b1, 2'b01, 4);
        run_burst("wrap4_rd", 1'b0, 2'b01, 4);

        // Master breaks the wrap sequence at beat 2 and restarts at 0x10.
        drive(1'b0, 32'h0C, 32'h0, 4'hF, 3'b010, 2'b01);
        step(); chk("mis.ack0", 32'(ack_a), 32'd1); chk("mis.dat0", dat_a, 32'hC0C0_0003);
        step(); drive(1'b0, 32'h10, 32'h0, 4'hF, 3'b010, 2'b01);
        step(); chk("mis.drop", 32'(ack_a), 32'd0);
        step(); chk("mis.reack", 32'(ack_a), 32'd1); chk("mis.dat", dat_a, 32'hDEAD_BEEF);
        drive(1'b0, 32'h10, 32'h0, 4'hF, 3'b111, 2'b01);
        step(); chk("mis.end", 32'(ack_a), 32'd0);
        idle();

        for (int i = 0; i < 8; i++) begin
            b_adr[i] = 32'h200 + 32'(4 * i);
            b_wd[i]  = 32'h5000_0080 + 32'(i);
        end
        run_burst("pre_wr", 1'b1, 2'b00, 8);

        drive(1'b1, 32'h200, 32'hA000_0080, 4'hF, 3'b010, 2'b00);
        step(); chk("rb.ack1", 32'(ack_a), 32'd1);
        step(); drive(1'b1, 32'h204, 32'hA000_0081, 4'hF, 3'b010, 2'b00);
        chk("rb.ack2", 32'(ack_a), 32'd1);
        step(); drive(1'b1, 32'h208, 32'hA000_0082, 4'hF, 3'b010, 2'b00);
        chk("rb.ack3", 32'(ack_a), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("rb.ack_rst", 32'(ack_a), 32'd0);
        chk("rb.err_rst", 32'(err_a), 32'd0);
        chk("rb.dat_rst", dat_a, 32'd0);
        step();
        step();
        idle();
        @(negedge clk_i) rst_i = 1'b1;
        step();

        for (int i = 0; i < 8; i++) b_rd[i] = (i < 2) ? 32'hA000_0080 + 32'(i) : 32'h5000_0080 + 32'(i);
        run_burst("rb_rd", 1'b0, 2'b00, 8);

        oor_access("oor_rd", 1'b0, 32'h0);
        oor_access("oor_wr", 1'b1, 32'h1234_5678);
        oor_access("oor_rd2", 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
